// File: rtl/sigma_delta_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sigma_delta_pkg
//  Description : Shared constants and helpers for the sigma-delta DAC:
//                integrator width offset, saturation helpers, and the dither
//                LFSR seed / Galois tap mask.
//  Revision    : 1.0 - initial release
// ============================================================================
package sigma_delta_pkg;

  // Second-order integrators carry this many guard bits above the sample width.
  localparam int c_int_ofs = 4;

  // Galois LFSR for dither, taps 16,14,13,11 in right-shift form.
  localparam logic [15:0] c_lfsr_seed = 16'hACE1;
  localparam logic [15:0] c_lfsr_taps = 16'hB400;

  // Clamp x to the w-bit two's-complement range.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x,
                                                    input int w);
    logic signed [31:0] lim_hi;
    logic signed [31:0] lim_lo;
    lim_hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lim_lo = -(32'sd1 <<< (w - 1));
    if (x > lim_hi)      return lim_hi;
    else if (x < lim_lo) return lim_lo;
    else                 return x;
  endfunction

  // Clamp x to the w-bit unsigned range 0 .. 2^w-1.
  function automatic logic [31:0] sat_unsigned(input logic signed [31:0] x,
                                               input int w);
    logic signed [31:0] lim_hi;
    lim_hi = (32'sd1 <<< w) - 32'sd1;
    if (x < 32'sd0)      return 32'd0;
    else if (x > lim_hi) return 32'(lim_hi);
    else                 return 32'(x);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sigma_delta_dac_if.sv
`default_nettype none
// ============================================================================
//  Module      : sigma_delta_dac_if
//  Description : Sample/control and output bundle of one DAC channel.
//                master : sample source (drives enable, signed_in, d, d_stb)
//                slave  : the DAC (drives q, tick)
//  Parameters  : signalwidth - sample width, must match the DAC instance
//  Revision    : 1.0 - initial release
// ============================================================================
interface sigma_delta_dac_if #(
  parameter int signalwidth = 16
);
  logic                   enable;
  logic                   signed_in;
  logic [signalwidth-1:0] d;
  logic                   d_stb;
  logic                   q;
  logic                   tick;

  modport master (output enable, output signed_in, output d, output d_stb,
                  input  q, input tick);
  modport slave  (input  enable, input signed_in, input d, input d_stb,
                  output q, output tick);
endinterface
`default_nettype wire

// File: rtl/sdm_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : sdm_lfsr16
//  Description : 16-bit Galois LFSR dither source; steps once per advance.
//                Only present when SIGMA_DELTA_DAC_DITHER_EN is defined.
//  Ports       : clk, reset_n (async, active-low), advance (step enable),
//                lfsr (current state)
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef SIGMA_DELTA_DAC_DITHER_EN
module sdm_lfsr16
  import sigma_delta_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        advance,
  output logic [15:0] lfsr
);
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_lfsr <= c_lfsr_seed;
    else if (advance) r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_lfsr_taps : 16'h0000);
  end

  assign lfsr = r_lfsr;
endmodule
`endif
`default_nettype wire

// File: rtl/sigma_delta_dac.sv
`default_nettype none
// ============================================================================
//  Module      : sigma_delta_dac
//  Description : First/second-order sigma-delta DAC producing a 1-bit
//                pulse-density stream from a W-bit sample, updated every
//                clkdiv enabled clk cycles.
//  Parameters  : signalwidth (4..24), order (1|2), clkdiv (1..65535)
//  Ports       : clk, reset_n (async, active-low)
//                bus.slave: enable, signed_in, d, d_stb in; q, tick out
//  Macro       : SIGMA_DELTA_DAC_DITHER_EN adds LFSR dither to the modulator
//  Revision    : 1.0 - initial release
// ============================================================================
module sigma_delta_dac
  import sigma_delta_pkg::*;
#(
  parameter int signalwidth = 16,
  parameter int order       = 1,
  parameter int clkdiv      = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  sigma_delta_dac_if.slave  bus
);
  localparam int          c_w        = signalwidth;
  localparam int          c_iw       = signalwidth + c_int_ofs;
  localparam logic [15:0] c_div_last = 16'(clkdiv - 1);

  logic [c_w-1:0] r_samp;
  logic [15:0]    r_divcnt;
  logic           r_tick;
  logic           w_update;
  logic           w_q;

  // Sample capture is independent of enable and of the update cadence.
  // Signed input is mapped to offset binary by flipping the sign bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_samp <= '0;
    else if (bus.d_stb) r_samp <= bus.signed_in ? {~bus.d[c_w-1], bus.d[c_w-2:0]} : bus.d;
  end

  assign w_update = bus.enable && (r_divcnt == c_div_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_divcnt <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= w_update;
      if (bus.enable) r_divcnt <= w_update ? 16'd0 : r_divcnt + 16'd1;
    end
  end

`ifdef SIGMA_DELTA_DAC_DITHER_EN
  logic [15:0]       w_lfsr;
  logic signed [1:0] w_dither;

  sdm_lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (w_update),
    .lfsr    (w_lfsr)
  );
  assign w_dither = $signed(w_lfsr[1:0]);
`endif

  if (signalwidth < 4 || signalwidth > 24) begin : g_bad_width
    $error("sigma_delta_dac: signalwidth must be 4..24");
  end
  if (clkdiv < 1 || clkdiv > 65535) begin : g_bad_div
    $error("sigma_delta_dac: clkdiv must be 1..65535");
  end

  if (order == 1) begin : g_order1
    logic [c_w:0]   r_acc;
    logic [c_w:0]   w_sum;
    logic [c_w-1:0] w_u_eff;

`ifdef SIGMA_DELTA_DAC_DITHER_EN
    assign w_u_eff = c_w'(sat_unsigned(32'(signed'({1'b0, r_samp})) + 32'(w_dither), c_w));
`else
    assign w_u_eff = r_samp;
`endif

    // The previous carry is dropped; the new carry is the output bit, so
    // the top bit of the accumulator doubles as the registered q.
    assign w_sum = {1'b0, r_acc[c_w-1:0]} + {1'b0, w_u_eff};

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      r_acc <= '0;
      else if (w_update) r_acc <= w_sum;
    end

    assign w_q = r_acc[c_w];
  end else if (order == 2) begin : g_order2
    localparam logic signed [c_w:0] c_half = {2'b01, {(c_w-1){1'b0}}};

    logic signed [c_iw-1:0] r_i1;
    logic signed [c_iw-1:0] r_i2;
    logic                   r_q;
    logic signed [c_w:0]    w_xs;
    logic signed [c_w:0]    w_xs_d;
    logic signed [c_w:0]    w_fb;
    logic signed [31:0]     w_i1_sum;
    logic signed [31:0]     w_i2_sum;
    logic signed [c_iw-1:0] w_i1_new;
    logic signed [c_iw-1:0] w_i2_new;

    assign w_xs = $signed({1'b0, r_samp}) - c_half;
`ifdef SIGMA_DELTA_DAC_DITHER_EN
    assign w_xs_d = w_xs + (c_w+1)'(w_dither);
`else
    assign w_xs_d = w_xs;
`endif
    assign w_fb = r_q ? c_half : -c_half;

    // Sums are formed at 32 bits so the clamp sees the true value.
    assign w_i1_sum = 32'(r_i1) + 32'(w_xs_d) - 32'(w_fb);
    assign w_i1_new = c_iw'(sat_signed(w_i1_sum, c_iw));
    assign w_i2_sum = 32'(r_i2) + 32'(w_i1_new) - 32'(w_fb);
    assign w_i2_new = c_iw'(sat_signed(w_i2_sum, c_iw));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_i1 <= '0;
        r_i2 <= '0;
        r_q  <= 1'b0;
      end else if (w_update) begin
        r_i1 <= w_i1_new;
        r_i2 <= w_i2_new;
        r_q  <= ~w_i2_new[c_iw-1];
      end
    end

    assign w_q = r_q;
  end else begin : g_bad_order
    $error("sigma_delta_dac: order must be 1 or 2");
  end

  assign bus.q    = w_q;
  assign bus.tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_sigma_delta_dac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sigma_delta_dac
//  Description : Directed self-checking bench for sigma_delta_dac. Three
//                instances: W=8/order1/clkdiv1, W=8/order1/clkdiv4,
//                W=12/order2/clkdiv1. Inputs driven and outputs sampled on
//                the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sigma_delta_dac;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sigma_delta_dac_if #(.signalwidth(8))  bus1 ();
  sigma_delta_dac_if #(.signalwidth(8))  bus4 ();
  sigma_delta_dac_if #(.signalwidth(12)) bus2 ();

  sigma_delta_dac #(.signalwidth(8), .order(1), .clkdiv(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));
  sigma_delta_dac #(.signalwidth(8), .order(1), .clkdiv(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4.slave));
  sigma_delta_dac #(.signalwidth(12), .order(2), .clkdiv(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  initial begin
    logic [7:0]  pat8;
    logic [11:0] pat12t;
    logic [11:0] pat12q;
    logic [5:0]  pat6t;
    logic [5:0]  pat6q;
    int          ones;
    int          ticks;
    int          n;

    reset_n = 1'b0;
    bus1.enable = 1'b0; bus1.signed_in = 1'b0; bus1.d = '0; bus1.d_stb = 1'b0;
    bus4.enable = 1'b0; bus4.signed_in = 1'b0; bus4.d = '0; bus4.d_stb = 1'b0;
    bus2.enable = 1'b0; bus2.signed_in = 1'b0; bus2.d = '0; bus2.d_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bus1.q, bus1.tick, bus4.q, bus4.tick, bus2.q, bus2.tick}), 32'd0);

    // Release with samp=0: q stays low, tick high every cycle at clkdiv=1.
    reset_n = 1'b1;
    bus1.enable = 1'b1;
    ones = 0; ticks = 0;
    repeat (20) begin
      @(negedge clk);
      ones  += int'(bus1.q);
      ticks += int'(bus1.tick);
    end
    check("o1_zero_ones", 32'(ones), 32'd0);
    check("div1_tick_continuous", 32'(ticks), 32'd20);

    // Unsigned 0x40: q = 0,0,0,1 repeating from the first update after capture.
    bus1.d = 8'h40; bus1.d_stb = 1'b1;
    @(negedge clk);
    bus1.d_stb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat8[i] = bus1.q;
    end
    check("o1_h40_pattern", 32'(pat8), 32'h88);

    // Signed 0x80 maps to u=0: never a one.
    bus1.signed_in = 1'b1; bus1.d = 8'h80; bus1.d_stb = 1'b1;
    @(negedge clk);
    bus1.d_stb = 1'b0;
    ones = 0;
    repeat (300) begin
      @(negedge clk);
      ones += int'(bus1.q);
    end
    check("signed_h80_ones", 32'(ones), 32'd0);

    // Signed 0x7F maps to u=0xFF: exactly 255 ones per 256 updates.
    bus1.d = 8'h7F; bus1.d_stb = 1'b1;
    @(negedge clk);
    bus1.d_stb = 1'b0;
    ones = 0;
    repeat (256) begin
      @(negedge clk);
      ones += int'(bus1.q);
    end
    check("signed_h7f_ones", 32'(ones), 32'd255);

    // Accumulator low byte is 0x40 here. Strobe u=0 on an update edge:
    // old u=0xFF gives 0x40+0xFF -> carry 1; then u=0 gives 0x3F -> 0.
    bus1.signed_in = 1'b0; bus1.d = 8'h00; bus1.d_stb = 1'b1;
    @(negedge clk);
    bus1.d_stb = 1'b0;
    check("stb_on_update_uses_old", 32'(bus1.q), 32'd1);
    @(negedge clk);
    check("stb_next_update_uses_new", 32'(bus1.q), 32'd0);

    // clkdiv=4: capture while disabled, then run. u=0x80 -> q toggles per update.
    bus4.d = 8'h80; bus4.d_stb = 1'b1;
    @(negedge clk);
    bus4.d_stb = 1'b0;
    check("div4_disabled_no_tick", 32'(bus4.tick), 32'd0);
    bus4.enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pat12t[i] = bus4.tick;
      pat12q[i] = bus4.q;
    end
    check("div4_tick_pattern", 32'(pat12t), 32'h888);
    check("div4_q_pattern", 32'(pat12q), 32'h780);
    repeat (6) @(negedge clk);   // update 4 at enabled edge 16, divcnt=2 after edge 18
    check("div4_q_before_freeze", 32'(bus4.q), 32'd1);

    bus4.enable = 1'b0;
    ticks = 0; ones = 0;
    repeat (10) begin
      @(negedge clk);
      ticks += int'(bus4.tick);
      ones  += int'(bus4.q);
    end
    check("freeze_no_tick", 32'(ticks), 32'd0);
    check("freeze_q_held", 32'(ones), 32'd10);

    bus4.enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat6t[i] = bus4.tick;
      pat6q[i] = bus4.q;
    end
    check("resume_tick_pattern", 32'(pat6t), 32'h22);
    check("resume_q_pattern", 32'(pat6q), 32'h21);

    // Order 2, W=12: DC u=1024 from reset state -> quarter density.
    bus2.d = 12'd1024; bus2.d_stb = 1'b1;
    @(negedge clk);
    bus2.d_stb = 1'b0;
    bus2.enable = 1'b1;
    ones = 0;
    repeat (4096) begin
      @(negedge clk);
      ones += int'(bus2.q);
    end
    check_range("o2_u1024_ones", ones, 1022, 1026);

    bus2.d = 12'd4095; bus2.d_stb = 1'b1;
    @(negedge clk);
    bus2.d_stb = 1'b0;
    ones = 0;
    repeat (4096) begin
      @(negedge clk);
      ones += int'(bus2.q);
    end
    check_range("o2_u4095_ones", ones, 4090, 4096);

    // Mid-stream asynchronous reset with q high.
    bus1.d = 8'hFF; bus1.d_stb = 1'b1;
    @(negedge clk);
    bus1.d_stb = 1'b0;
    n = 0;
    while (bus1.q !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_q_high", 32'(bus1.q), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_immediate", 32'({bus1.q, bus1.tick}), 32'd0);
    ones = 0;
    repeat (5) begin
      @(negedge clk);
      ones += int'(bus1.q) + int'(bus1.tick) + int'(bus4.q) + int'(bus4.tick)
            + int'(bus2.q) + int'(bus2.tick);
    end
    check("reset_held_outputs", 32'(ones), 32'd0);
    reset_n = 1'b1;
    ones = 0;
    repeat (20) begin
      @(negedge clk);
      ones += int'(bus1.q);
    end
    check("post_reset_samp_zero", 32'(ones), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
